fpu_vec_checker: RTL
====================

FPU_VEC_CHECKER -- requirements
Module: fpu_vec_checker

Interface
REQ-001 Parameter W, default 64: operand/result width.
REQ-002 Parameter AW, default 24: vector memory address width.
REQ-003 Parameter LAT, default 3, legal 1..8: DUT latency, first operand cycle to result cycle.
REQ-004 Parameter CW, default 16: error counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset: synchronous, active-high.
REQ-007 start  in  1  one-cycle run request; sampled in IDLE or DONE only.
REQ-008 num_vec  in  AW  vectors to run; sampled with start.
REQ-009 stop_on_err  in  1  1 = halt on first mismatch, 0 = run to end; sampled with start.
REQ-010 cmp_mask  in  W  bit set = compared bit; sampled with start.
REQ-011 mem_rd  out  1  vector memory read strobe.
REQ-012 mem_addr  out  AW  vector read address.
REQ-013 mem_data  in  3W+1  {sub,exp,B,A}; valid one cycle after mem_rd.
REQ-014 dut_vld, dut_sub  out  1 each  operand valid, subtract select.
REQ-015 dut_A, dut_B  out  W each  operands.
REQ-016 dut_res  in  W  DUT result, valid LAT cycles after matching dut_vld.
REQ-017 busy, done, pass  out  1 each  run status.
REQ-018 err_cnt  out  CW  mismatch count, saturating.
REQ-019 first_err_addr  out  AW; first_err_got, first_err_exp  out  W each  first-mismatch capture.

Function
REQ-020 States: IDLE, ISSUE, DRAIN, DONE; one-hot or binary at implementer's choice.
REQ-021 IDLE/DONE + start, num_vec>0 -> ISSUE; clear err_cnt, first_err_*, done, pass; latch run config.
REQ-022 IDLE/DONE + start, num_vec==0 -> DONE next cycle with pass=1, err_cnt=0.
REQ-023 ISSUE: mem_rd=1 every cycle, mem_addr = 0,1,2,... ; after address num_vec-1 issued -> DRAIN.
REQ-024 Cycle after each mem_rd: dut_vld=1, dut_A/B/sub driven combinationally from mem_data.
REQ-025 dut_vld=0 -> dut_A, dut_B, dut_sub driven 0.
REQ-026 Expected pipe: depth LAT, carrying {valid, addr, exp} aligned to dut_res.
REQ-027 Pipe output valid: mismatch iff ((dut_res ^ exp) & cmp_mask) != 0.
REQ-028 Mismatch: err_cnt += 1, saturating at 2^CW-1.
REQ-029 First mismatch of run only: capture addr, dut_res, exp into first_err_*.
REQ-030 Throughput one vector/cycle; total run = num_vec + LAT + 1 cycles from first mem_rd to done.
REQ-031 DRAIN -> DONE when expected pipe holds no valid entry and no read is outstanding.
REQ-032 stop_on_err=1 and mismatch: same cycle stop issuing, invalidate every pipe entry, next state DONE; in-flight results not compared or counted.
REQ-033 DONE: done=1, busy=0, pass=(err_cnt==0); state held until start or rst.
REQ-034 busy=1 in ISSUE and DRAIN only.
REQ-035 start in ISSUE/DRAIN ignored, no effect on run.
REQ-036 mem_addr holds last issued value outside ISSUE.
REQ-037 Address arithmetic AW bits; num_vec = 2^AW-1 runs without wrap.

Reset
REQ-038 rst=1: state IDLE; busy, done, pass, mem_rd, dut_vld, dut_A, dut_B, dut_sub = 0; mem_addr=0; err_cnt=0; first_err_*=0; all pipe valids=0.
REQ-039 rst mid-run aborts immediately; no compare or count in reset cycle; post-reset outputs per REQ-038.

Verification
REQ-040 LAT=3, num_vec=8, DUT echoes exp after 3 cycles -> done 12 cycles after first mem_rd, pass=1, err_cnt=0.
REQ-041 num_vec=8, stop_on_err=0, vectors 2 and 5 corrupted -> err_cnt=2, first_err_addr=2, pass=0, all 8 compared.
REQ-042 stop_on_err=1, vector 3 corrupted -> mem_rd stops same cycle, DONE next cycle, err_cnt=1, first_err_addr=3; vectors 4+ never counted.
REQ-043 cmp_mask=~64'h1, results differ in bit 0 only -> pass=1; differ in bit 63 -> mismatch.
REQ-044 num_vec=0 -> done=1, pass=1 one cycle after start, no mem_rd ever asserted.
REQ-045 CW=2, 5 mismatches -> err_cnt=3; rst asserted during ISSUE -> all outputs 0 next cycle, IDLE, start then reruns cleanly.

Source files
------------

// File: rtl/fpu_vec_checker.sv
// Vector-driven checker for a pipelined FPU: streams {sub,exp,B,A} vectors from memory,
// feeds operands to the DUT and compares its results LAT cycles later against the expected values.
module fpu_vec_checker #(
    parameter int W   = 64,
    parameter int AW  = 24,
    parameter int LAT = 3,
    parameter int CW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   num_vec,
    input  logic            stop_on_err,
    input  logic [W-1:0]    cmp_mask,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [3*W:0]    mem_data,
    output logic            dut_vld,
    output logic            dut_sub,
    output logic [W-1:0]    dut_A,
    output logic [W-1:0]    dut_B,
    input  logic [W-1:0]    dut_res,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CW-1:0]   err_cnt,
    output logic [AW-1:0]   first_err_addr,
    output logic [W-1:0]    first_err_got,
    output logic [W-1:0]    first_err_exp
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_numVec;
    logic          r_stopOnErr;
    logic [W-1:0]  r_mask;
    logic [AW-1:0] r_addr;
    logic          r_rdPend;
    logic [AW-1:0] r_rdAddr;
    logic          r_pipeVld  [LAT];
    logic [AW-1:0] r_pipeAddr [LAT];
    logic [W-1:0]  r_pipeExp  [LAT];
    logic [CW-1:0] r_errCnt;
    logic [AW-1:0] r_firstAddr;
    logic [W-1:0]  r_firstGot;
    logic [W-1:0]  r_firstExp;

    logic          w_mismatch;
    logic          w_halt;
    logic          w_lastAddr;
    logic          w_pipeBusy;
    logic          w_drainEmpty;
    logic [W-1:0]  w_memExp;

    assign w_memExp     = mem_data[3*W-1:2*W];
    assign w_mismatch   = r_pipeVld[LAT-1] && ((dut_res ^ r_pipeExp[LAT-1]) & r_mask) != '0;
    assign w_halt       = w_mismatch && r_stopOnErr;
    assign w_lastAddr   = (r_addr == r_numVec - AW'(1));
    assign w_drainEmpty = !r_rdPend && !w_pipeBusy;

    // The last pipe stage is being consumed this cycle, so only earlier stages count as pending work.
    always_comb begin
        w_pipeBusy = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            w_pipeBusy = w_pipeBusy | r_pipeVld[k];
        end
    end

    assign mem_rd         = (r_state == S_ISSUE) && !w_halt;
    assign mem_addr       = r_addr;
    assign dut_vld        = r_rdPend;
    assign dut_A          = r_rdPend ? mem_data[W-1:0]   : '0;
    assign dut_B          = r_rdPend ? mem_data[2*W-1:W] : '0;
    assign dut_sub        = r_rdPend ? mem_data[3*W]     : 1'b0;
    assign busy           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign pass           = (r_state == S_DONE) && (r_errCnt == '0);
    assign err_cnt        = r_errCnt;
    assign first_err_addr = r_firstAddr;
    assign first_err_got  = r_firstGot;
    assign first_err_exp  = r_firstExp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_numVec    <= '0;
            r_stopOnErr <= 1'b0;
            r_mask      <= '0;
            r_addr      <= '0;
            r_errCnt    <= '0;
            r_firstAddr <= '0;
            r_firstGot  <= '0;
            r_firstExp  <= '0;
        end else begin
            if (w_mismatch) begin
                if (r_errCnt != '1) begin
                    r_errCnt <= r_errCnt + CW'(1);
                end
                if (r_errCnt == '0) begin
                    r_firstAddr <= r_pipeAddr[LAT-1];
                    r_firstGot  <= dut_res;
                    r_firstExp  <= r_pipeExp[LAT-1];
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_errCnt    <= '0;
                        r_firstAddr <= '0;
                        r_firstGot  <= '0;
                        r_firstExp  <= '0;
                        if (num_vec != '0) begin
                            r_state     <= S_ISSUE;
                            r_addr      <= '0;
                            r_numVec    <= num_vec;
                            r_stopOnErr <= stop_on_err;
                            r_mask      <= cmp_mask;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_halt) begin
                        r_state <= S_DONE;
                    end else if (w_lastAddr) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_halt || w_drainEmpty) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Expected-value pipe; a stop-on-error halt flushes every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPend <= 1'b0;
            r_rdAddr <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_pipeVld[k]  <= 1'b0;
                r_pipeAddr[k] <= '0;
                r_pipeExp[k]  <= '0;
            end
        end else begin
            r_rdPend <= mem_rd;
            if (mem_rd) begin
                r_rdAddr <= r_addr;
            end
            r_pipeVld[0]  <= dut_vld && !w_halt;
            r_pipeAddr[0] <= r_rdAddr;
            r_pipeExp[0]  <= w_memExp;
            for (int k = 1; k < LAT; k++) begin
                r_pipeVld[k]  <= r_pipeVld[k-1] && !w_halt;
                r_pipeAddr[k] <= r_pipeAddr[k-1];
                r_pipeExp[k]  <= r_pipeExp[k-1];
            end
        end
    end

endmodule
